// File: rtl/leiwand_rv32_bus_arbiter.sv
// Two-master round-robin arbiter in front of the single leiwand_rv32_ram slave.
// One owner per cyc span, registered grant decision, and an ack watchdog that aborts stuck cycles.
module leiwand_rv32_bus_arbiter #(
   parameter int MEM_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [2*MEM_WIDTH-1:0] i_m_addr,
   input  logic [2*MEM_WIDTH-1:0] i_m_dat,
   input  logic [1:0]             i_m_we,
   input  logic [1:0]             i_m_stb,
   input  logic [1:0]             i_m_cyc,
   input  logic [5:0]             i_m_wr_size,
   output logic [MEM_WIDTH-1:0]   o_m_dat,
   output logic [1:0]             o_m_ack,
   output logic [1:0]             o_m_stall,
   output logic [1:0]             o_m_err,
   output logic [MEM_WIDTH-1:0]   o_s_addr,
   output logic [MEM_WIDTH-1:0]   o_s_dat,
   output logic                   o_s_we,
   output logic                   o_s_stb,
   output logic                   o_s_cyc,
   output logic [2:0]             o_s_wr_size,
   input  logic [MEM_WIDTH-1:0]   i_s_dat,
   input  logic                   i_s_ack,
   input  logic                   i_s_stall,
   output logic [1:0]             o_grant
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

   state_t           state, state_nxt;
   logic             last_grant, last_grant_nxt;
   logic             owner, owner_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [MEM_WIDTH-1:0] m_addr    [2];
   logic [MEM_WIDTH-1:0] m_dat     [2];
   logic [2:0]           m_wr_size [2];

   for (genvar n = 0; n < 2; n++) begin : g_unpack
      assign m_addr[n]    = i_m_addr[n*MEM_WIDTH +: MEM_WIDTH];
      assign m_dat[n]     = i_m_dat[n*MEM_WIDTH +: MEM_WIDTH];
      assign m_wr_size[n] = i_m_wr_size[n*3 +: 3];
   end

   // last_grant resets to 1 so master 0 wins the first tie
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         cnt        <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         owner      <= owner_nxt;
         cnt        <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      owner_nxt      = owner;
      cnt_nxt        = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (i_m_cyc != 2'b00) begin
               if (i_m_cyc == 2'b11) owner_nxt = ~last_grant;
               else                  owner_nxt = i_m_cyc[1];
               state_nxt = owner_nxt ? GNT1 : GNT0;
            end
         end
         GNT0, GNT1: begin
            // cyc drop beats both ack and expiry; ack beats expiry
            if (!i_m_cyc[owner]) begin
               state_nxt      = IDLE;
               last_grant_nxt = owner;
               cnt_nxt        = '0;
            end else if (i_s_ack) begin
               cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ABORT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ABORT: begin
            state_nxt      = IDLE;
            last_grant_nxt = owner;
            cnt_nxt        = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_m_dat = i_s_dat;

   always_comb begin
      o_m_stall   = 2'b11;
      o_m_ack     = 2'b00;
      o_m_err     = 2'b00;
      o_grant     = 2'b00;
      o_s_addr    = '0;
      o_s_dat     = '0;
      o_s_we      = 1'b0;
      o_s_stb     = 1'b0;
      o_s_cyc     = 1'b0;
      o_s_wr_size = 3'd0;
      case (state)
         GNT0, GNT1: begin
            o_s_addr         = m_addr[owner];
            o_s_dat          = m_dat[owner];
            o_s_we           = i_m_we[owner];
            o_s_cyc          = i_m_cyc[owner];
            o_s_stb          = i_m_stb[owner] & i_m_cyc[owner];
            o_s_wr_size      = m_wr_size[owner];
            o_m_stall[owner] = i_s_stall;
            o_m_ack[owner]   = i_s_ack;
            o_grant[owner]   = 1'b1;
         end
         ABORT:   o_m_err[owner] = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_leiwand_rv32_bus_arbiter.sv
// Directed bench for leiwand_rv32_bus_arbiter; the slave side is driven by hand step by step.
module tb_leiwand_rv32_bus_arbiter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2*W-1:0] m_addr, m_dat;
   logic [1:0]   m_we, m_stb, m_cyc;
   logic [5:0]   m_wr_size;
   logic [W-1:0] m_dat_o;
   logic [1:0]   m_ack, m_stall, m_err, grant;
   logic [W-1:0] s_addr, s_dat_o, s_dat;
   logic         s_we, s_stb, s_cyc, s_ack, s_stall;
   logic [2:0]   s_wr_size;
   logic [W-1:0] mem8;

   int checks = 0;
   int errors = 0;

   leiwand_rv32_bus_arbiter #(.MEM_WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m_addr(m_addr), .i_m_dat(m_dat), .i_m_we(m_we), .i_m_stb(m_stb),
      .i_m_cyc(m_cyc), .i_m_wr_size(m_wr_size),
      .o_m_dat(m_dat_o), .o_m_ack(m_ack), .o_m_stall(m_stall), .o_m_err(m_err),
      .o_s_addr(s_addr), .o_s_dat(s_dat_o), .o_s_we(s_we), .o_s_stb(s_stb),
      .o_s_cyc(s_cyc), .o_s_wr_size(s_wr_size),
      .i_s_dat(s_dat), .i_s_ack(s_ack), .i_s_stall(s_stall),
      .o_grant(grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n = 1'b0; m_addr = '0; m_dat = '0; m_we = 2'b00; m_stb = 2'b00;
      m_cyc = 2'b00; m_wr_size = 6'd0; s_dat = '0; s_ack = 1'b0; s_stall = 1'b0;
      mem8 = '0;

      // reset and idle
      tick(); tick();
      chk("rst_stall", m_stall, 2'b11);
      chk("rst_grant", grant, 2'b00);
      chk("rst_scyc", s_cyc, 1'b0);
      chk("rst_ack", m_ack, 2'b00);
      chk("rst_saddr", s_addr, 32'h0);
      rst_n = 1'b1;
      tick(); tick();
      chk("idle_stall", m_stall, 2'b11);
      chk("idle_grant", grant, 2'b00);
      chk("idle_scyc", s_cyc, 1'b0);

      // stb without cyc is ignored
      m_stb = 2'b10;
      tick();
      chk("stb_only_grant", grant, 2'b00);
      m_stb = 2'b00;

      // single master 0 read of 0x4
      m_cyc = 2'b01; m_stb = 2'b01; m_addr[31:0] = 32'h4;
      settle();
      chk("m0rd_arb_stall", m_stall, 2'b11);
      chk("m0rd_arb_grant", grant, 2'b00);
      tick();
      chk("m0rd_grant", grant, 2'b01);
      chk("m0rd_saddr", s_addr, 32'h4);
      chk("m0rd_sstb", s_stb, 1'b1);
      chk("m0rd_stall", m_stall, 2'b10);
      s_ack = 1'b1; s_dat = 32'h0015_8593; m_stb = 2'b00;
      settle();
      chk("m0rd_ack", m_ack, 2'b01);
      chk("m0rd_dat", m_dat_o, 32'h0015_8593);
      tick();
      s_ack = 1'b0; m_cyc = 2'b00;
      settle();
      chk("m0rd_ack_gone", m_ack, 2'b00);
      chk("m0rd_m1stall", m_stall[1], 1'b1);
      tick();
      chk("m0rd_idle", grant, 2'b00);

      // simultaneous requests out of reset, round-robin
      rst_n = 1'b0; settle(); rst_n = 1'b1;
      m_cyc = 2'b11; m_stb = 2'b11; m_addr = {32'h20, 32'h10};
      tick();
      chk("rr_first", grant, 2'b01);
      chk("rr_first_addr", s_addr, 32'h10);
      chk("rr_first_stall", m_stall, 2'b10);
      m_cyc = 2'b10; m_stb = 2'b10;
      settle();
      chk("rr_drop_scyc", s_cyc, 1'b0);
      tick();
      chk("rr_gap_grant", grant, 2'b00);
      chk("rr_gap_stall", m_stall, 2'b11);
      tick();
      chk("rr_second", grant, 2'b10);
      chk("rr_second_addr", s_addr, 32'h20);
      chk("rr_second_stall", m_stall, 2'b01);
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();
      m_cyc = 2'b11; m_stb = 2'b11;
      settle();
      chk("rr_idle2", grant, 2'b00);
      tick();
      chk("rr_third", grant, 2'b01);
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();

      // master 1 writes 0xDEADBEEF to 0x8, master 0 reads it back
      m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
      m_addr = {32'h8, 32'h0}; m_dat = {32'hDEAD_BEEF, 32'h0}; m_wr_size = {3'd4, 3'd0};
      tick();
      chk("wr_grant", grant, 2'b10);
      chk("wr_we", s_we, 1'b1);
      chk("wr_addr", s_addr, 32'h8);
      chk("wr_dat", s_dat_o, 32'hDEAD_BEEF);
      chk("wr_size", s_wr_size, 3'd4);
      if (s_we && s_addr == 32'h8) mem8 = s_dat_o;
      s_ack = 1'b1; m_stb = 2'b00;
      settle();
      chk("wr_ack", m_ack, 2'b10);
      tick();
      s_ack = 1'b0; m_cyc = 2'b00; m_we = 2'b00;
      tick();
      m_cyc = 2'b01; m_stb = 2'b01; m_addr = {32'h0, 32'h8};
      tick();
      chk("rd8_addr", s_addr, 32'h8);
      chk("rd8_we", s_we, 1'b0);
      s_ack = 1'b1; s_dat = mem8; m_stb = 2'b00;
      settle();
      chk("rd8_ack", m_ack, 2'b01);
      chk("rd8_dat", m_dat_o, 32'hDEAD_BEEF);
      tick();
      s_ack = 1'b0; m_cyc = 2'b00;
      tick();

      // watchdog: no ack, abort after 8 cycles in GNT0
      m_cyc = 2'b01; m_stb = 2'b01; m_addr = {32'h0, 32'h4};
      tick();
      for (int i = 0; i < 7; i++) begin
         chk("wd_hold_grant", grant, 2'b01);
         chk("wd_hold_err", m_err, 2'b00);
         tick();
      end
      chk("wd_last_grant", grant, 2'b01);
      chk("wd_last_err", m_err, 2'b00);
      tick();
      s_ack = 1'b1;
      settle();
      chk("wd_err", m_err, 2'b01);
      chk("wd_scyc", s_cyc, 1'b0);
      chk("wd_sstb", s_stb, 1'b0);
      chk("wd_stall", m_stall, 2'b11);
      chk("wd_ack_dropped", m_ack, 2'b00);
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();
      s_ack = 1'b0;
      settle();
      chk("wd_err_gone", m_err, 2'b00);
      chk("wd_idle", grant, 2'b00);

      // asynchronous reset in the middle of a GNT1 cycle
      m_cyc = 2'b10; m_stb = 2'b10;
      tick();
      chk("ar_grant", grant, 2'b10);
      rst_n = 1'b0;
      settle();
      chk("ar_grant_rst", grant, 2'b00);
      chk("ar_stall_rst", m_stall, 2'b11);
      chk("ar_scyc_rst", s_cyc, 1'b0);
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
